// File: rtl/seed_ram_wb_slave_if.sv
// Wishbone classic-cycle bus bundle for the seed RAM responder.
// Signal names keep the responder-side _i/_o suffixes so the bus reads the
// same at both ends; the master modport simply flips the directions.
interface seed_ram_wb_slave_if #(
   parameter int aw = 32,
   parameter int dw = 32
);
   logic [aw-1:0] wb_adr_i;
   logic [dw-1:0] wb_dat_i;
   logic [dw-1:0] wb_dat_o;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic          wb_we_i;
   logic [3:0]    wb_sel_i;
   logic          wb_cab_i;
   logic          wb_ack_o;
   logic          wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_cab_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_cab_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/seed_ram_wb_slave.sv
// Wishbone classic-cycle responder in front of the on-chip seed RAM.
// A request is captured and decoded in IDLE, optionally held for a fixed
// number of wait states, then answered with exactly one registered ack or
// err beat. Zero-fill coverage is tracked with one valid bit per word while
// init_active_i is high.
module seed_ram_wb_slave #(
   parameter int            dw          = 32,
   parameter int            aw          = 32,
   parameter logic [aw-1:0] BASE_ADDR   = '0,
   parameter int            DEPTH_WORDS = 256,
   parameter int            WAIT_STATES = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   seed_ram_wb_slave_if.slave            wb,
   input  logic                          init_active_i,
   output logic                          init_done_o,
   output logic [$clog2(DEPTH_WORDS):0]  init_count_o
);

   localparam int            IW         = $clog2(DEPTH_WORDS);
   localparam logic [aw-1:0] SPAN       = aw'(4 * DEPTH_WORDS);
   localparam logic [IW:0]   FULL_COUNT = (IW+1)'(DEPTH_WORDS);
   localparam logic [IW:0]   COUNT_ONE  = (IW+1)'(1);
   localparam logic [3:0]    WAIT_LOAD  = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } fsmStateT;

   fsmStateT            state;
   logic [3:0]          waitCnt;

   // Captured, already-decoded request.
   logic                capHit;
   logic                capWe;
   logic [IW-1:0]       capIdx;
   logic [dw-1:0]       capDat;
   logic [3:0]          capSel;

   // Registered bus outputs.
   logic                ackQ;
   logic                errQ;
   logic [dw-1:0]       datQ;

   // Storage.
   logic [dw-1:0]       mem [DEPTH_WORDS];

   // Zero-fill coverage.
   logic                initActiveQ;
   logic                initRise;
   logic [DEPTH_WORDS-1:0] validBits;
   logic [DEPTH_WORDS-1:0] validNext;
   logic [IW:0]         countNext;

   // Address decode on the live bus, used only at capture time.
   logic [aw-1:0]       offset;
   logic                reqHit;
   logic [IW-1:0]       reqIdx;
   logic                commitWrite;
   logic                unusedCab;

   // Subtracting the base lets one unsigned compare reject both addresses
   // below the window (they wrap to large values) and those above it.
   assign offset      = wb.wb_adr_i - BASE_ADDR;
   assign reqHit      = (offset < SPAN) && (wb.wb_adr_i[1:0] == 2'b00);
   assign reqIdx      = offset[IW+1:2];

   // The burst hint carries no meaning here: every beat is a single access.
   assign unusedCab   = wb.wb_cab_i;

   // The RAM write and the coverage update both land on the RESP edge.
   assign commitWrite = (state == RESP) && capHit && capWe;

   assign wb.wb_ack_o = ackQ;
   assign wb.wb_err_o = errQ;
   assign wb.wb_dat_o = datQ;

   // Bus FSM: capture, optional wait states, then one registered ack/err beat.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state   <= IDLE;
         waitCnt <= '0;
         ackQ    <= 1'b0;
         errQ    <= 1'b0;
         datQ    <= '0;
         capHit  <= 1'b0;
         capWe   <= 1'b0;
         capIdx  <= '0;
         capDat  <= '0;
         capSel  <= '0;
      end else begin
         ackQ <= 1'b0;
         errQ <= 1'b0;
         case (state)
            IDLE: begin
               if (wb.wb_cyc_i && wb.wb_stb_i) begin
                  capHit <= reqHit;
                  capWe  <= wb.wb_we_i;
                  capIdx <= reqIdx;
                  capDat <= wb.wb_dat_i;
                  capSel <= wb.wb_sel_i;
                  if (WAIT_STATES == 0) begin
                     state <= RESP;
                  end else begin
                     state   <= WAIT;
                     waitCnt <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               // An initiator that drops cyc while we stall abandons the access.
               if (!wb.wb_cyc_i) begin
                  state <= IDLE;
               end else if (waitCnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            RESP: begin
               if (capHit) begin
                  ackQ <= 1'b1;
                  // Reads return the whole word; sel only matters for writes.
                  if (!capWe) begin
                     datQ <= mem[capIdx];
                  end
               end else begin
                  errQ <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-lane RAM write on the RESP edge; reset wins and drops the write.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array is deliberately left out of reset so it maps onto
      // a plain memory macro; the zero-fill engine initialises it instead.
      if (!rst && commitWrite) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (capSel[lane]) begin
               mem[capIdx][8*lane +: 8] <= capDat[8*lane +: 8];
            end
         end
      end
   end

   // Next coverage state: a rising init edge clears first, then a committing write is scored.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      initRise  = init_active_i && !initActiveQ;
      validNext = initRise ? '0 : validBits;
      countNext = initRise ? '0 : init_count_o;
      if (commitWrite && init_active_i) begin
         if ((capSel == 4'hF) && (capDat == '0)) begin
            if (!validNext[capIdx]) begin
               validNext[capIdx] = 1'b1;
               countNext         = countNext + COUNT_ONE;
            end
         end else if (validNext[capIdx]) begin
            validNext[capIdx] = 1'b0;
            countNext         = countNext - COUNT_ONE;
         end
      end
   end

   // Coverage registers; done follows the count and holds after init falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         initActiveQ  <= 1'b0;
         validBits    <= '0;
         init_count_o <= '0;
         init_done_o  <= 1'b0;
      end else begin
         initActiveQ  <= init_active_i;
         validBits    <= validNext;
         init_count_o <= countNext;
         init_done_o  <= (countNext == FULL_COUNT);
      end
   end

endmodule

// File: tb/tb_seed_ram_wb_slave.sv
// Self-checking bench for seed_ram_wb_slave: one responder with no wait
// states (nonzero base, 16 words) and one with three wait states (zero base,
// 64 words). Expected values come from hand tables and a word-array model.
module tb_seed_ram_wb_slave;

   localparam int          D0  = 16;
   localparam int          D1  = 64;
   localparam logic [31:0] B0  = 32'h0000_1000;
   localparam logic [31:0] B1  = 32'h0000_0000;
   localparam int          WS0 = 0;
   localparam int          WS1 = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, datW;
   logic [3:0]  sel;
   int          tgt;
   logic        initAct0, initAct1;
   logic        done0, done1;
   logic [4:0]  cnt0;
   logic [6:0]  cnt1;

   always #5 clk = ~clk;

   seed_ram_wb_slave_if #(.aw(32), .dw(32)) bus0 ();
   seed_ram_wb_slave_if #(.aw(32), .dw(32)) bus1 ();

   assign bus0.wb_adr_i = adr;
   assign bus0.wb_dat_i = datW;
   assign bus0.wb_we_i  = we;
   assign bus0.wb_sel_i = sel;
   assign bus0.wb_cab_i = 1'b0;
   assign bus0.wb_cyc_i = cyc && (tgt == 0);
   assign bus0.wb_stb_i = stb && (tgt == 0);
   assign bus1.wb_adr_i = adr;
   assign bus1.wb_dat_i = datW;
   assign bus1.wb_we_i  = we;
   assign bus1.wb_sel_i = sel;
   assign bus1.wb_cab_i = 1'b1;
   assign bus1.wb_cyc_i = cyc && (tgt == 1);
   assign bus1.wb_stb_i = stb && (tgt == 1);

   seed_ram_wb_slave #(.dw(32), .aw(32), .BASE_ADDR(B0), .DEPTH_WORDS(D0), .WAIT_STATES(WS0)) dut0 (
      .clk(clk), .rst(rst), .wb(bus0),
      .init_active_i(initAct0), .init_done_o(done0), .init_count_o(cnt0));

   seed_ram_wb_slave #(.dw(32), .aw(32), .BASE_ADDR(B1), .DEPTH_WORDS(D1), .WAIT_STATES(WS1)) dut1 (
      .clk(clk), .rst(rst), .wb(bus1),
      .init_active_i(initAct1), .init_done_o(done1), .init_count_o(cnt1));

   int tests  = 0;
   int failed = 0;

   // Reference model: word contents, last read data, zero-fill coverage.
   logic [31:0] refMem [2][64];
   logic [31:0] lastDat [2];
   bit          valid0 [D0];
   bit          initModel;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        expAck;
      logic        expErr;
      logic [31:0] expDat;
   } vecT;

   vecT vecs [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int depthOf(input int d);
      return (d == 0) ? D0 : D1;
   endfunction

   function automatic logic [31:0] baseOf(input int d);
      return (d == 0) ? B0 : B1;
   endfunction

   function automatic int wsOf(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic logic ackOf(input int d);
      return (d == 0) ? bus0.wb_ack_o : bus1.wb_ack_o;
   endfunction

   function automatic logic errOf(input int d);
      return (d == 0) ? bus0.wb_err_o : bus1.wb_err_o;
   endfunction

   function automatic logic [31:0] datOf(input int d);
      return (d == 0) ? bus0.wb_dat_o : bus1.wb_dat_o;
   endfunction

   function automatic bit modelHit(input int d, input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(baseOf(d));
      return (a[1:0] == 2'b00) && (off >= 0) && (off < 4 * depthOf(d));
   endfunction

   function automatic int modelIdx(input int d, input logic [31:0] a);
      return int'((longint'(a) - longint'(baseOf(d))) / 4);
   endfunction

   function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      end
      return r;
   endfunction

   function automatic int modelCount();
      int n;
      n = 0;
      for (int i = 0; i < D0; i++) n += int'(valid0[i]);
      return n;
   endfunction

   task automatic modelClearInit();
      for (int i = 0; i < D0; i++) valid0[i] = 1'b0;
   endtask

   task automatic modelUpdate(input int d, input logic [31:0] a, input logic w,
                              input logic [31:0] dat, input logic [3:0] s);
      int idx;
      if (!modelHit(d, a)) return;
      idx = modelIdx(d, a);
      if (w) begin
         refMem[d][idx] = laneMerge(refMem[d][idx], dat, s);
         if (d == 0 && initModel) valid0[idx] = (s == 4'hF) && (dat == 32'h0);
      end else begin
         lastDat[d] = refMem[d][idx];
      end
   endtask

   // One bus access; starts and ends #1 after a rising edge. holdExtra keeps
   // stb up one cycle past the ack, like the zero-fill engine does.
   task automatic wbAccess(input int d, input logic [31:0] a, input logic w, input logic [31:0] dat,
                           input logic [3:0] s, input bit holdExtra,
                           output logic gotAck, output logic gotErr, output logic [31:0] gotDat,
                           output int lat);
      tgt = d; adr = a; we = w; datW = dat; sel = s;
      cyc = 1'b1; stb = 1'b1;
      gotAck = 1'b0; gotErr = 1'b0; gotDat = '0; lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (ackOf(d) || errOf(d)) begin
            gotAck = ackOf(d); gotErr = errOf(d); gotDat = datOf(d); lat = k;
            break;
         end
      end
      if (holdExtra) begin
         @(posedge clk); #1;
      end
      cyc = 1'b0; stb = 1'b0;
      if (holdExtra) begin
         repeat (3) begin @(posedge clk); #1; end
      end
   endtask

   // Access checked against the model, then folded into it.
   task automatic checkAccess(input string name, input int d, input logic [31:0] a, input logic w,
                              input logic [31:0] dat, input logic [3:0] s, input bit holdExtra);
      logic        gAck, gErr;
      logic [31:0] gDat, eDat;
      int          lat;
      bit          hit;
      hit  = modelHit(d, a);
      eDat = (hit && !w) ? refMem[d][modelIdx(d, a)] : lastDat[d];
      wbAccess(d, a, w, dat, s, holdExtra, gAck, gErr, gDat, lat);
      check({name, "_ack"}, 64'(gAck), 64'(hit));
      check({name, "_err"}, 64'(gErr), 64'(!hit));
      check({name, "_lat"}, 64'(lat), 64'(wsOf(d) + 2));
      check({name, "_dat"}, 64'(gDat), 64'(eDat));
      modelUpdate(d, a, w, dat, s);
   endtask

   initial begin
      logic        gAck, gErr;
      logic [31:0] gDat, a, dv;
      int          lat, resp, d, kind, idx;

      vecs[0]  = '{32'h0000_1000, 1'b1, 32'h0102_0304, 4'hF, 1'b1, 1'b0, 32'h0000_0000};
      vecs[1]  = '{32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0000_0000};
      vecs[2]  = '{32'h0000_1008, 1'b0, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h0000_1010, 1'b1, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[4]  = '{32'h0000_1010, 1'b1, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[5]  = '{32'h0000_1010, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h11BB_33DD};
      vecs[6]  = '{32'h0000_1040, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
      vecs[7]  = '{32'h0000_1002, 1'b0, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
      vecs[8]  = '{32'h0000_0FFC, 1'b0, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
      vecs[9]  = '{32'h0000_1000, 1'b0, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'h0102_0304};
      vecs[10] = '{32'h0000_1008, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0102_0304};
      vecs[11] = '{32'h0000_1008, 1'b0, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[12] = '{32'h0000_103C, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[13] = '{32'h0000_103C, 1'b0, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D};
      vecs[14] = '{32'h0000_100A, 1'b1, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D};
      vecs[15] = '{32'h0000_1008, 1'b0, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; datW = '0; sel = '0; tgt = 0;
      initAct0 = 1'b0; initAct1 = 1'b0; initModel = 1'b0;
      lastDat[0] = '0; lastDat[1] = '0;
      modelClearInit();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out0", {bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, done0, cnt0}, 64'h0);
      check("rst_out1", {bus1.wb_ack_o, bus1.wb_err_o, bus1.wb_dat_o, done1, cnt1}, 64'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table on the zero-wait-state responder.
      for (int i = 0; i < 16; i++) begin
         wbAccess(0, vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, 1'b0, gAck, gErr, gDat, lat);
         check($sformatf("vec%0d_ack", i), 64'(gAck), 64'(vecs[i].expAck));
         check($sformatf("vec%0d_err", i), 64'(gErr), 64'(vecs[i].expErr));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(WS0 + 2));
         check($sformatf("vec%0d_dat", i), 64'(gDat), 64'(vecs[i].expDat));
         modelUpdate(0, vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel);
      end

      // Three wait states: latency, then an access abandoned mid-wait.
      checkAccess("ws3_wr", 1, 32'h20, 1'b1, 32'h55AA_55AA, 4'hF, 1'b0);
      checkAccess("ws3_rd", 1, 32'h20, 1'b0, 32'h0, 4'hF, 1'b0);
      tgt = 1; adr = 32'h20; we = 1'b1; datW = 32'h1234_5678; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      resp = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus1.wb_ack_o || bus1.wb_err_o) resp++;
      end
      check("abort_noresp", 64'(resp), 64'h0);
      checkAccess("abort_rd", 1, 32'h20, 1'b0, 32'h0, 4'hF, 1'b0);

      // Zero-fill pass from the top word down, engine-style stb release.
      initAct0 = 1'b1;
      @(posedge clk); #1;
      initModel = 1'b1;
      modelClearInit();
      check("init_clr_cnt", 64'(cnt0), 64'h0);
      for (int w = D0 - 1; w >= 0; w--) begin
         a = B0 + 32'(4 * w);
         checkAccess($sformatf("fill%0d", w), 0, a, 1'b1, 32'h0, 4'hF, 1'b1);
         if (w == 12) checkAccess("fill_twice", 0, a, 1'b1, 32'h0, 4'hF, 1'b0);
         if (w == 10) begin
            checkAccess("fill_nz", 0, a, 1'b1, 32'h5, 4'hF, 1'b0);
            check("fill_nz_cnt", 64'(cnt0), 64'(modelCount()));
            checkAccess("fill_part", 0, a, 1'b1, 32'h0, 4'h3, 1'b0);
            checkAccess("fill_redo", 0, a, 1'b1, 32'h0, 4'hF, 1'b0);
         end
         check($sformatf("fill%0d_cnt", w), 64'(cnt0), 64'(modelCount()));
         check($sformatf("fill%0d_done", w), 64'(done0), 64'(modelCount() == D0));
      end
      check("init_full_cnt", 64'(cnt0), 64'(D0));
      check("init_full_done", 64'(done0), 64'h1);
      initAct0 = 1'b0;
      initModel = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("init_hold_cnt", 64'(cnt0), 64'(D0));
      check("init_hold_done", 64'(done0), 64'h1);
      checkAccess("post_init_wr", 0, B0, 1'b1, 32'h77, 4'hF, 1'b0);
      check("post_init_cnt", 64'(cnt0), 64'(D0));
      initAct0 = 1'b1;
      @(posedge clk); #1;
      initModel = 1'b1;
      modelClearInit();
      check("rearm_cnt", 64'(cnt0), 64'h0);
      check("rearm_done", 64'(done0), 64'h0);
      initAct0 = 1'b0;
      initModel = 1'b0;
      @(posedge clk); #1;

      // Rising init edge coinciding with a write commit: clear, then count.
      tgt = 0; adr = B0 + 32'hC; we = 1'b1; datW = 32'h0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      initAct0 = 1'b1;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      initModel = 1'b1;
      modelClearInit();
      modelUpdate(0, B0 + 32'hC, 1'b1, 32'h0, 4'hF);
      check("coinc_ack", 64'(bus0.wb_ack_o), 64'h1);
      check("coinc_cnt", 64'(cnt0), 64'(modelCount()));
      check("coinc_done", 64'(done0), 64'h0);
      initAct0 = 1'b0;
      initModel = 1'b0;
      @(posedge clk); #1;

      // Randomised traffic against the model on both responders.
      for (int i = 0; i < D1; i++) begin
         checkAccess($sformatf("pre%0d", i), 1, B1 + 32'(4 * i), 1'b1, $urandom, 4'hF, 1'b0);
      end
      for (int i = 0; i < 120; i++) begin
         d    = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         idx  = int'($urandom_range(0, depthOf(d) - 1));
         if (kind <= 6)      a = baseOf(d) + 32'(4 * idx);
         else if (kind == 7) a = baseOf(d) + 32'(4 * idx) + 32'($urandom_range(1, 3));
         else if (kind == 8) a = baseOf(d) + 32'(4 * depthOf(d)) + 32'(4 * $urandom_range(0, 3));
         else                a = (d == 0) ? baseOf(d) - 32'h4 : 32'hFFFF_FFFC;
         dv = $urandom;
         checkAccess($sformatf("rnd%0d", i), d, a, 1'($urandom_range(0, 1)), dv,
                     4'($urandom_range(0, 15)), 1'b0);
      end

      // Reset in the middle of a stalled write.
      tgt = 1; adr = B1 + 32'h14; we = 1'b1; datW = ~refMem[1][5]; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      check("midrst_out0", {bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, done0, cnt0}, 64'h0);
      check("midrst_out1", {bus1.wb_ack_o, bus1.wb_err_o, bus1.wb_dat_o, done1, cnt1}, 64'h0);
      rst = 1'b0;
      lastDat[0] = '0; lastDat[1] = '0;
      modelClearInit();
      resp = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus1.wb_ack_o || bus1.wb_err_o) resp++;
      end
      check("midrst_noresp", 64'(resp), 64'h0);
      checkAccess("midrst_rd", 1, B1 + 32'h14, 1'b0, 32'h0, 4'hF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/seed_ram_wb_slave.md
Name: seed_ram_wb_slave

Overview:
Wishbone classic-cycle responder that fronts the on-chip seed RAM. It accepts word and byte-lane writes and reads from any Wishbone initiator, including the seed-RAM zero-fill engine triggered by l.start. It generates registered ack/err responses with programmable wait states. It also tracks zero-fill coverage and flags when a full zero-initialisation pass has completed.

Parameters:
dw, 32, data bus width (fixed 32; 4 byte lanes)
aw, 32, address bus width
BASE_ADDR, 32'h0000_0000, byte address of seed RAM word 0
DEPTH_WORDS, 256, number of 32-bit words (power of two, >=2)
WAIT_STATES, 0, extra cycles inserted between request capture and ack/err (0..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_adr_i  in  aw  byte address
wb_dat_i  in  dw  write data
wb_dat_o  out  dw  read data, valid in the ack cycle
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write, 0=read
wb_sel_i  in  4  byte lane enables; bit n selects dat[8n+7:8n]
wb_cab_i  in  1  burst hint; ignored, every beat is handled as a single access
wb_ack_o  out  1  one-cycle normal termination
wb_err_o  out  1  one-cycle error termination
init_active_i  in  1  high while the zero-fill engine runs
init_done_o  out  1  every word zero-written during the current init window
init_count_o  out  clog2(DEPTH_WORDS)+1  count of distinct zero-writes in the window

Behaviour:
- Reset (rst=1 at a clk edge): wb_ack_o=0, wb_err_o=0, wb_dat_o=0, init_done_o=0, init_count_o=0, FSM=IDLE, wait counter=0.
- RAM contents are not reset.
- Reset has priority over all other events. A request that has not yet been acked when reset occurs is dropped: no write, no response.
- Request = wb_cyc_i & wb_stb_i sampled in IDLE. On a request, the block registers adr/dat/we/sel.
  - WAIT_STATES=0: FSM goes to RESP.
  - WAIT_STATES>0: FSM goes to WAIT with the counter loaded to WAIT_STATES-1.
- WAIT:
  - If wb_cyc_i drops, the access aborts: return to IDLE, no write, no response.
  - Otherwise, when the counter reaches 0, go to RESP; else decrement.
- RESP: drive exactly one of ack/err high for one cycle, then return to IDLE.
  - Latency: request sampled at edge N gives a response visible after edge N+1+WAIT_STATES.
- The cycle after RESP is IDLE. If stb is still high there, it is treated as a new request (back-to-back beats are allowed).
- Decode is evaluated at capture:
  - Hit when BASE_ADDR <= adr < BASE_ADDR+4*DEPTH_WORDS and adr[1:0]==0.
  - Word index = (adr-BASE_ADDR)>>2, truncated to clog2(DEPTH_WORDS) bits.
  - Miss or misalignment gives err in RESP, RAM unchanged, wb_dat_o unchanged.
- Write hit: the RAM word is updated on the RESP edge, only on lanes where sel=1. sel=0000 gives ack with no change.
- Read hit: wb_dat_o = full RAM word, registered so it is valid in the ack cycle; sel is ignored for reads.
  - wb_dat_o holds its value until the next read ack.
- Read immediately after a write to the same word returns the new data (no stale read).
- Init tracking, one valid bit per word:
  - A rising edge of init_active_i (registered compare) clears all valid bits, init_count_o and init_done_o in that cycle.
  - While init_active_i=1, a write hit with sel=1111 and dat=0 whose word valid bit is 0 sets that bit and increments init_count_o.
  - A rewrite of the same word does not increment init_count_o.
  - A nonzero write or a partial write (sel!=1111) to a valid word during init clears its bit and decrements the count.
  - init_done_o = (init_count_o==DEPTH_WORDS), registered. It stays asserted after init_active_i falls until the next rising edge of init_active_i or reset.
- The rising edge of init_active_i and a write ack in the same cycle: the clear is applied first, then the write is counted.

Test Plan:
- WAIT_STATES=0, write 32'hDEADBEEF sel=1111 to BASE+8, then read BASE+8 -> each ack one cycle after stb; read returns DEADBEEF; err never asserted.
- Byte lanes: write 32'h11223344 sel=1111, then 32'hAABBCCDD sel=0101, read back -> 32'h11BB33DD.
- Errors: access BASE+4*DEPTH_WORDS and BASE+2 -> err one cycle, ack=0, RAM and wb_dat_o unchanged.
- WAIT_STATES=3: request at edge N -> ack after edge N+4. In a second access, drop cyc at N+2 -> no ack, no write.
- Init: raise init_active_i; emulate the zero-fill master writing zero to all words from the top address down, dropping stb one cycle after each ack, with one word written twice -> init_count_o=DEPTH_WORDS, init_done_o=1 after the last ack and held after init_active_i falls. Re-raise init_active_i -> count and done clear.
- Assert rst mid-WAIT of a write -> no ack, target word unchanged, all outputs 0 next cycle.
